// File: rtl/mode_counter.sv
// mode_counter: registered up/down counter with runtime limit, wrap or
// saturate behaviour at the boundaries, parallel load, a terminal-count
// pulse and a sticky overflow flag. A RUN/HOLD FSM remembers that the
// count is parked at a boundary in saturate mode.
module mode_counter #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             held
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VAL);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             held_q, held_d;

  // Result of one enabled counting step as taken from RUN
  logic [WIDTH-1:0] step_count_s;
  logic             step_event_s;
  state_t           step_state_s;
  // Direction points away from the boundary the count is parked on
  logic             away_s;
  logic [WIDTH-1:0] load_clamped_s;

  assign away_s         = up_dn ? (count_q < limit) : (count_q > ZERO_C);
  assign load_clamped_s = (load_val > limit) ? limit : load_val;

  // One enabled step: clamp after a lowered limit, else count or hit a boundary
  always_comb begin
    step_count_s = count_q;
    step_event_s = 1'b0;
    step_state_s = ST_RUN;
    if (count_q > limit) begin
      step_count_s = limit;
    end else if (up_dn) begin
      if (count_q < limit) begin
        step_count_s = count_q + ONE_C;
      end else begin
        step_event_s = 1'b1;
        if (sat_mode) begin
          step_state_s = ST_HOLD;
        end else begin
          step_count_s = ZERO_C;
        end
      end
    end else begin
      if (count_q > ZERO_C) begin
        step_count_s = count_q - ONE_C;
      end else begin
        step_event_s = 1'b1;
        if (sat_mode) begin
          step_state_s = ST_HOLD;
        end else begin
          step_count_s = limit;
        end
      end
    end
  end

  // Next-state logic: load beats enable; HOLD only steps when released
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = load_clamped_s;
      state_d = ST_RUN;
    end else if (en) begin
      case (state_q)
        ST_RUN: begin
          count_d = step_count_s;
          state_d = step_state_s;
          tc_d    = step_event_s;
          ovf_d   = (ovf_q & ~clr_ovf) | step_event_s;
        end
        ST_HOLD: begin
          // A dropped sat_mode releases HOLD and the step uses the wrap rule
          if (away_s || !sat_mode) begin
            count_d = step_count_s;
            state_d = step_state_s;
            tc_d    = step_event_s;
            ovf_d   = (ovf_q & ~clr_ovf) | step_event_s;
          end else begin
            count_d = count_q;
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end else begin
      count_d = count_q;
      state_d = state_q;
    end
    held_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= RST_C;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      held_q  <= held_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign held  = held_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: each step drives inputs, queues the
// expected registered outputs and compares them one clock later.
module tb_mode_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, load, up_dn, sat_mode, clr_ovf;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         tc, ovf, held;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         t;
    logic         o;
    logic         h;
    string        tag;
  } exp_t;

  exp_t sb_q[$];

  mode_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .limit    (limit),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .held     (held)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    checks = checks + 1;
    assert (sb_q.size() > 0) else begin
      errors = errors + 1;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks = checks + 4;
      assert (count === e.c) else begin
        errors = errors + 1;
        $error("FAIL %s.count observed=%0d expected=%0d", e.tag, count, e.c);
      end
      assert (tc === e.t) else begin
        errors = errors + 1;
        $error("FAIL %s.tc observed=%b expected=%b", e.tag, tc, e.t);
      end
      assert (ovf === e.o) else begin
        errors = errors + 1;
        $error("FAIL %s.ovf observed=%b expected=%b", e.tag, ovf, e.o);
      end
      assert (held === e.h) else begin
        errors = errors + 1;
        $error("FAIL %s.held observed=%b expected=%b", e.tag, held, e.h);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [W-1:0] lv, input logic u, input logic s,
                      input logic [W-1:0] lim, input logic c,
                      input logic [W-1:0] xc, input logic xt,
                      input logic xo, input logic xh, input string tag);
    exp_t x;
    rst = r; en = e; load = l; load_val = lv; up_dn = u;
    sat_mode = s; limit = lim; clr_ovf = c;
    x.c = xc; x.t = xt; x.o = xo; x.h = xh; x.tag = tag;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    //     rst  en   ld   lv    up   sat  lim   clr   cnt   tc   ovf  held
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");

    // Up, wrap, limit 5
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, "wrap_up1");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, "wrap_up2");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "wrap_up3");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "wrap_up4");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, "wrap_up5");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "wrap_up0");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, "wrap_up1b");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "wrap_up2b");

    // Saturate up, limit 3 (load 0 while clearing ovf)
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "sat_load");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, "sat_up1");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, "sat_up2");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "sat_up3");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, "sat_hit");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, "sat_hold");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "sat_leave");

    // Down, wrap, limit 9; load clamping
    step(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd9, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, "dn_load1");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "dn_0");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, "dn_wrap9");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, "dn_8");
    step(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, "load_clamp");

    // Limit lowered below the count
    step(1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 4'd10, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, "lim_load8");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "lim_clamp");
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "idle_hold");

    // clr_ovf against a concurrent wrap, then alone
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "clr_vs_set");
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "clr_alone");

    // limit 0, wrap: every enabled cycle is an event
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "lim0_a");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "lim0_b");

    // sat_mode dropped while in HOLD releases with the wrap rule
    step(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, "rel_load");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, "rel_hold");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "rel_wrap");

    // Reset mid-run with load and en asserted, from a HOLD state
    step(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "pre_load");
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, "pre_hold");
    step(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "rst_prio");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
